// File: rtl/switch_pkg.sv
// switch_pkg: packet types, word field positions and target classification
// shared by the ingress, fabric and egress stages of the 4-port switch.
package switch_pkg;
    typedef enum logic [1:0] {SINGLE = 2'd0, MULTICAST = 2'd1, BROADCAST = 2'd2, ILLEGAL = 2'd3} ptype_t;
    localparam int PKT_W = 16;
    localparam int TGT_LSB = 0;
    localparam int SRC_LSB = 4;
    localparam int DATA_LSB = 8;
    // A target with a single bit set addresses exactly one port.
    function automatic ptype_t classify_target(input logic [3:0] tgt);
        return (tgt == 4'd0) ? ILLEGAL :
               (tgt == 4'hF) ? BROADCAST :
               ((tgt & (tgt - 4'd1)) == 4'd0) ? SINGLE : MULTICAST;
    endfunction
endpackage

// File: rtl/port_rx_fifo.sv
// port_rx_fifo: synchronous FIFO with wrap-bit pointers; reads as zero when empty.
module port_rx_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic do_push, do_pop;
    always_comb begin
        count = wr_ptr_q - rd_ptr_q;
        empty = wr_ptr_q == rd_ptr_q;
        full = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop = pop && !empty;
        do_push = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + CW'(do_push);
        rd_ptr_d = rd_ptr_q + CW'(do_pop);
        mem_d = mem_q;
        if (do_push) mem_d[wr_ptr_q[AW-1:0]] = din;
        dout = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
    // Storage needs no reset: empty masks stale entries on dout.
    always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/port_rx_buffer.sv
// port_rx_buffer: per-port ingress stage; classifies incoming packets, buffers
// them for the fabric, drives backpressure and counts dropped packets.
module port_rx_buffer
    import switch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PORTNO = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_ip,
    input  logic [15:0] data_ip,
    output logic        suspend_ip,
    output logic        fab_valid,
    output logic [15:0] fab_data,
    output logic [1:0]  fab_ptype,
    input  logic        fab_ready,
    output logic        drop_pulse,
    output logic [7:0]  drop_count
);
    localparam int CW = $clog2(DEPTH) + 1;
    if (PORTNO < 0 || PORTNO > 3) begin : g_bad_portno
        $error("port_rx_buffer: PORTNO %0d out of range", PORTNO);
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("port_rx_buffer: DEPTH %0d must be a power of two >= 2", DEPTH);
    end
    ptype_t ptype;
    logic [17:0] head;
    logic full, empty, pop, accept, drop;
    logic [CW-1:0] occ, occ_next;
    logic suspend_q, suspend_d, drop_pulse_q, drop_pulse_d;
    logic [7:0] drop_count_q, drop_count_d;
    always_comb begin
        ptype = classify_target(data_ip[TGT_LSB +: 4]);
        pop = !empty && fab_ready;
        // A pop on the same edge frees the slot, so a full FIFO still accepts.
        accept = valid_ip && ptype != ILLEGAL && (!full || pop);
        drop = valid_ip && !accept;
        occ_next = occ + CW'(accept) - CW'(pop);
        suspend_d = occ_next == CW'(DEPTH);
        drop_pulse_d = drop;
        drop_count_d = drop_count_q + 8'(drop && drop_count_q != 8'hFF);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            suspend_q <= 1'b0;
            drop_pulse_q <= 1'b0;
            drop_count_q <= 8'd0;
        end else begin
            suspend_q <= suspend_d;
            drop_pulse_q <= drop_pulse_d;
            drop_count_q <= drop_count_d;
        end
    end
    port_rx_fifo #(.WIDTH(18), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .pop   (pop),
        .din   ({ptype, data_ip}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (occ)
    );
    assign fab_valid = !empty;
    assign fab_data = head[15:0];
    assign fab_ptype = head[17:16];
    assign suspend_ip = suspend_q;
    assign drop_pulse = drop_pulse_q;
    assign drop_count = drop_count_q;
endmodule

// File: tb/tb_port_rx_buffer.sv
// tb_port_rx_buffer: directed scenarios for the port ingress buffer with
// hand-computed expectations.
module tb_port_rx_buffer;
    import switch_pkg::*;
    logic clk = 1'b0, reset = 1'b0, valid_ip = 1'b0, fab_ready = 1'b0;
    logic [15:0] data_ip = 16'h0;
    logic suspend_ip, fab_valid, drop_pulse;
    logic [15:0] fab_data;
    logic [1:0] fab_ptype;
    logic [7:0] drop_count;
    int errors = 0, checks = 0;

    port_rx_buffer #(.DEPTH(4), .PORTNO(1)) dut (
        .clk(clk), .reset(reset), .valid_ip(valid_ip), .data_ip(data_ip),
        .suspend_ip(suspend_ip), .fab_valid(fab_valid), .fab_data(fab_data),
        .fab_ptype(fab_ptype), .fab_ready(fab_ready), .drop_pulse(drop_pulse),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pkt(input logic [7:0] d, input logic [3:0] s, input logic [3:0] t);
        logic [15:0] w;
        w = '0;
        w[DATA_LSB +: 8] = d;
        w[SRC_LSB +: 4] = s;
        w[TGT_LSB +: 4] = t;
        return w;
    endfunction

    task automatic fill4(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
        fab_ready = 1'b0;
        valid_ip = 1'b1;
        data_ip = a; tick();
        data_ip = b; tick();
        data_ip = c; tick();
        data_ip = d; tick();
        valid_ip = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (fab_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", fab_valid); end
        checks++; if (fab_data !== 16'h0) begin errors++; $display("FAIL rst_data got %h want 0000", fab_data); end
        checks++; if (fab_ptype !== SINGLE) begin errors++; $display("FAIL rst_ptype got %0d want 0", fab_ptype); end
        checks++; if ({suspend_ip, drop_pulse, drop_count} !== 10'h0) begin errors++; $display("FAIL rst_misc got %b/%b/%0d want 0/0/0", suspend_ip, drop_pulse, drop_count); end
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        fab_ready = 1'b1;
        valid_ip = 1'b1; data_ip = 16'hA512; tick(); valid_ip = 1'b0;
        checks++; if (fab_valid !== 1'b1 || fab_data !== 16'hA512) begin errors++; $display("FAIL single_head got %b/%h want 1/a512", fab_valid, fab_data); end
        checks++; if (fab_ptype !== SINGLE || suspend_ip !== 1'b0) begin errors++; $display("FAIL single_type got %0d/%b want 0/0", fab_ptype, suspend_ip); end
        tick();
        checks++; if (fab_valid !== 1'b0) begin errors++; $display("FAIL single_popped got %b want 0", fab_valid); end
    endtask

    task automatic test_classify();
        fab_ready = 1'b1;
        valid_ip = 1'b1;
        data_ip = 16'h11BF; tick();
        checks++; if (fab_valid !== 1'b1 || fab_ptype !== BROADCAST || fab_data !== 16'h11BF) begin errors++; $display("FAIL cls_bcast got %b/%0d/%h want 1/2/11bf", fab_valid, fab_ptype, fab_data); end
        data_ip = 16'h22B6; tick();
        checks++; if (fab_valid !== 1'b1 || fab_ptype !== MULTICAST || fab_data !== 16'h22B6) begin errors++; $display("FAIL cls_mcast got %b/%0d/%h want 1/1/22b6", fab_valid, fab_ptype, fab_data); end
        data_ip = 16'h33B0; tick();
        valid_ip = 1'b0;
        checks++; if (fab_valid !== 1'b0) begin errors++; $display("FAIL cls_illegal_valid got %b want 0", fab_valid); end
        checks++; if (drop_pulse !== 1'b1 || drop_count !== 8'd1) begin errors++; $display("FAIL cls_drop got %b/%0d want 1/1", drop_pulse, drop_count); end
        tick();
        checks++; if (drop_pulse !== 1'b0 || drop_count !== 8'd1) begin errors++; $display("FAIL cls_drop_end got %b/%0d want 0/1", drop_pulse, drop_count); end
    endtask

    task automatic test_fill_drain();
        logic [15:0] exp [4];
        exp[0] = 16'h1101; exp[1] = 16'h2202; exp[2] = 16'h3304; exp[3] = 16'h4408;
        fab_ready = 1'b0;
        valid_ip = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_ip = exp[i]; tick();
            checks++; if (suspend_ip !== (i == 3)) begin errors++; $display("FAIL fill_suspend%0d got %b want %b", i, suspend_ip, i == 3); end
        end
        valid_ip = 1'b0;
        tick();
        checks++; if (fab_data !== 16'h1101 || suspend_ip !== 1'b1) begin errors++; $display("FAIL fill_hold got %h/%b want 1101/1", fab_data, suspend_ip); end
        fab_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            checks++; if (fab_valid !== 1'b1 || fab_data !== exp[i] || suspend_ip !== 1'b0) begin errors++; $display("FAIL drain%0d got %b/%h/%b want 1/%h/0", i, fab_valid, fab_data, suspend_ip, exp[i]); end
        end
        tick();
        checks++; if (fab_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b want 0", fab_valid); end
    endtask

    task automatic test_full_push_pop();
        logic [15:0] exp [4];
        fill4(16'h5101, 16'h5202, 16'h5303, 16'h5405);
        valid_ip = 1'b1; data_ip = 16'h550F; fab_ready = 1'b1; tick();
        valid_ip = 1'b0;
        checks++; if (drop_pulse !== 1'b0 || suspend_ip !== 1'b1 || fab_data !== 16'h5202) begin errors++; $display("FAIL fpp_edge got %b/%b/%h want 0/1/5202", drop_pulse, suspend_ip, fab_data); end
        exp[0] = 16'h5303; exp[1] = 16'h5405; exp[2] = 16'h550F; exp[3] = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (fab_valid !== 1'b1 || fab_data !== exp[i]) begin errors++; $display("FAIL fpp_order%0d got %b/%h want 1/%h", i, fab_valid, fab_data, exp[i]); end
        end
        checks++; if (fab_ptype !== BROADCAST) begin errors++; $display("FAIL fpp_last_type got %0d want 2", fab_ptype); end
        tick();
        checks++; if (fab_valid !== 1'b0 || drop_count !== 8'd1) begin errors++; $display("FAIL fpp_end got %b/%0d want 0/1", fab_valid, drop_count); end
    endtask

    task automatic test_overflow();
        logic [15:0] exp [4];
        exp[0] = 16'h6101; exp[1] = 16'h6202; exp[2] = 16'h6304; exp[3] = 16'h6408;
        fill4(exp[0], exp[1], exp[2], exp[3]);
        valid_ip = 1'b1; data_ip = 16'h6601; tick();
        valid_ip = 1'b0;
        checks++; if (drop_pulse !== 1'b1 || drop_count !== 8'd2 || suspend_ip !== 1'b1) begin errors++; $display("FAIL ovf_drop got %b/%0d/%b want 1/2/1", drop_pulse, drop_count, suspend_ip); end
        fab_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (fab_valid !== 1'b1 || fab_data !== exp[i]) begin errors++; $display("FAIL ovf_order%0d got %b/%h want 1/%h", i, fab_valid, fab_data, exp[i]); end
            tick();
        end
        checks++; if (fab_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b want 0", fab_valid); end
    endtask

    task automatic test_saturate();
        fab_ready = 1'b0;
        valid_ip = 1'b1; data_ip = pkt(8'h77, 4'h1, 4'h0);
        repeat (260) tick();
        checks++; if (drop_count !== 8'hFF || drop_pulse !== 1'b1) begin errors++; $display("FAIL sat_count got %0d/%b want 255/1", drop_count, drop_pulse); end
        valid_ip = 1'b0;
        tick();
        checks++; if (drop_count !== 8'hFF || fab_valid !== 1'b0) begin errors++; $display("FAIL sat_hold got %0d/%b want 255/0", drop_count, fab_valid); end
    endtask

    task automatic test_reset_mid();
        fab_ready = 1'b0;
        valid_ip = 1'b1;
        data_ip = 16'h7101; tick();
        data_ip = 16'h7202; tick();
        data_ip = 16'h7304; tick();
        valid_ip = 1'b0;
        checks++; if (fab_valid !== 1'b1 || fab_data !== 16'h7101 || suspend_ip !== 1'b0) begin errors++; $display("FAIL mid_pre got %b/%h/%b want 1/7101/0", fab_valid, fab_data, suspend_ip); end
        #2 reset = 1'b0;
        #1;
        checks++; if (fab_valid !== 1'b0 || fab_data !== 16'h0 || fab_ptype !== SINGLE) begin errors++; $display("FAIL mid_rst_fab got %b/%h/%0d want 0/0000/0", fab_valid, fab_data, fab_ptype); end
        checks++; if (drop_count !== 8'd0 || drop_pulse !== 1'b0 || suspend_ip !== 1'b0) begin errors++; $display("FAIL mid_rst_misc got %0d/%b/%b want 0/0/0", drop_count, drop_pulse, suspend_ip); end
        tick();
        @(negedge clk);
        reset = 1'b1;
        valid_ip = 1'b1; data_ip = pkt(8'h88, 4'h3, 4'h4);
        tick();
        valid_ip = 1'b0;
        checks++; if (fab_valid !== 1'b1 || fab_data !== 16'h8834 || fab_ptype !== SINGLE) begin errors++; $display("FAIL mid_after got %b/%h/%0d want 1/8834/0", fab_valid, fab_data, fab_ptype); end
        tick();
        checks++; if (fab_valid !== 1'b1 || fab_data !== 16'h8834) begin errors++; $display("FAIL mid_hold got %b/%h want 1/8834", fab_valid, fab_data); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_classify();
        test_fill_drain();
        test_full_push_pop();
        test_overflow();
        test_saturate();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
